// File: rtl/sobel_pkg.sv
// Shared types for the Sobel frame controller: FSM states, pixel type and
// counter-width helper.
package sobel_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int PIXEL_W = 8;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Synchronous output FIFO for Sobel results; DEPTH must be a power of two.
// Head data reads as zero while empty.
module sobel_out_fifo
    import sobel_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  pixel_t                     push_data,
    input  logic                       pop,
    output pixel_t                     pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around an external 1-cycle Sobel core with credit-based output FIFO.
// Define SOBEL_CTRL_STATS_EN to add the frame_count / stall_count outputs.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  pixel_t      s_pixel,
    output logic        m_valid,
    input  logic        m_ready,
    output pixel_t      m_pixel,
    output logic        m_last,
    output logic        core_rst,
    output logic        core_valid_in,
    output pixel_t      core_pixel_in,
    input  logic        core_valid_out,
    input  pixel_t      core_pixel_out,
    output logic        busy,
    output logic        done
`ifdef SOBEL_CTRL_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [31:0] stall_count
`endif
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int NOUT  = (WIDTH - 2) * (HEIGHT - 2);
    localparam int PIX_W = cnt_w(NPIX);
    localparam int OUT_W = cnt_w(NOUT);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state;
    logic [PIX_W-1:0]   pix_cnt;
    logic [OUT_W-1:0]   out_cnt;
    logic               issued_q;
    logic               beat;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               frame_end;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;

    // The pixel issued last cycle may still land in the FIFO, so it holds a credit.
    assign credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, issued_q};
    assign s_ready       = (state == RUN) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign beat          = s_valid && s_ready;
    assign core_valid_in = beat;
    assign core_pixel_in = beat ? s_pixel : '0;
    assign core_rst      = !rst_n || (state == CLEAR);
    assign busy          = (state != IDLE);

    assign push      = core_valid_out && issued_q;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign m_last    = m_valid && (out_cnt == OUT_W'(NOUT - 1));
    assign frame_end = (state == DRAIN) && pop && (out_cnt == OUT_W'(NOUT - 1));

    sobel_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (core_pixel_out),
        .pop       (pop),
        .pop_data  (m_pixel),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            out_cnt  <= '0;
            issued_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            issued_q <= beat;
            done     <= 1'b0;
            if (pop) out_cnt <= out_cnt + OUT_W'(1);
            case (state)
                IDLE: begin
                    if (start) state <= CLEAR;
                end
                CLEAR: begin
                    pix_cnt <= '0;
                    out_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (beat) begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                        if (pix_cnt == PIX_W'(NPIX - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_end) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOBEL_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (frame_end) frame_count <= frame_count + 16'd1;
            if (state == CLEAR)
                stall_count <= '0;
            else if ((state == RUN) && s_valid && !s_ready && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl with a behavioural 1-cycle Sobel core
// and a golden model computed directly from the frame image.
module tb_sobel_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int D  = 4;
    localparam int NP = W * H;
    localparam int NO = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] s_pixel = 8'h00;
    logic       s_ready, m_valid, m_last, core_rst, core_valid_in, busy, done;
    logic [7:0] m_pixel, core_pixel_in;
    logic       core_valid_out = 1'b0;
    logic [7:0] core_pixel_out = 8'h00;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_pixel        (s_pixel),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_pixel        (m_pixel),
        .m_last         (m_last),
        .core_rst       (core_rst),
        .core_valid_in  (core_valid_in),
        .core_pixel_in  (core_pixel_in),
        .core_valid_out (core_valid_out),
        .core_pixel_out (core_pixel_out),
        .busy           (busy),
        .done           (done)
    );

    // Sobel magnitude |gx|+|gy| saturated to 255, centred on (r,c).
    function automatic int sob(input int im[NP], input int r, input int c);
        int gx, gy;
        gx = (im[(r-1)*W+c+1] + 2*im[r*W+c+1] + im[(r+1)*W+c+1])
           - (im[(r-1)*W+c-1] + 2*im[r*W+c-1] + im[(r+1)*W+c-1]);
        gy = (im[(r+1)*W+c-1] + 2*im[(r+1)*W+c] + im[(r+1)*W+c+1])
           - (im[(r-1)*W+c-1] + 2*im[(r-1)*W+c] + im[(r-1)*W+c+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy > 255) ? 255 : gx + gy;
    endfunction

    // Core model: result one cycle after the window's bottom-right pixel; junk on idle cycles.
    int core_img[NP];
    int core_idx = 0;
    int cr, cc;
    always @(posedge clk) begin
        if (core_rst) begin
            core_idx = 0;
            core_valid_out <= 1'b0;
            core_pixel_out <= 8'h00;
        end else if (core_valid_in) begin
            if (core_idx < NP) begin
                core_img[core_idx] = int'(core_pixel_in);
                cr = core_idx / W;
                cc = core_idx % W;
                core_idx = core_idx + 1;
            end else begin
                cr = 0;
                cc = 0;
            end
            if (cr >= 2 && cc >= 2) begin
                core_valid_out <= 1'b1;
                core_pixel_out <= 8'(sob(core_img, cr - 1, cc - 1));
            end else begin
                core_valid_out <= 1'b0;
                core_pixel_out <= 8'h00;
            end
        end else begin
            core_valid_out <= 1'($urandom_range(0, 1));
            core_pixel_out <= 8'hEE;
        end
    end

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
        int         cyc;
    } obs_t;

    obs_t obs_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   max_cnt = 0;
    int   full_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) obs_q.push_back({m_pixel, m_last, cyc});
            if (done) done_cnt = done_cnt + 1;
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if ((int'(dut.u_fifo.count) == D) && s_ready) full_viol = full_viol + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic make_img(input int kind, output int im[NP]);
        for (int i = 0; i < NP; i++) begin
            case (kind)
                0: im[i] = 4 * (i / W) + (i % W);
                1: im[i] = ((i % W) < W / 2) ? 255 : 0;
                2: im[i] = 255;
                3: im[i] = 10 * (i % W);
                4: im[i] = ((i / W) < H / 2) ? 255 : 0;
                default: im[i] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic golden(input int im[NP], output int exp_o[NO]);
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_o[(r-1)*(W-2) + (c-1)] = sob(im, r, c);
    endtask

    task automatic run_frame(input int im[NP], input int exp_o[NO], input int vmode,
                             input int rmode, input int inj, input string tag);
        int   base, d0, idx, k, doneat;
        logic acc, seen;
        obs_t o;
        base = obs_q.size();
        d0   = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_clear"}, int'({core_rst, busy, s_ready}), 6);
        @(posedge clk); #1;
        idx = 0;
        k   = 0;
        while (idx < NP && k < 2000) begin
            case (vmode)
                0: s_valid = 1'b1;
                1: s_valid = (k % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_pixel = 8'(im[idx]);
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = (k >= 40);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = (inj != 0) && (k % 5 == 3);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx = idx + 1;
            k = k + 1;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        chk({tag, "_beats"}, idx, NP);
        @(negedge clk);
        chk({tag, "_drain_entry"}, int'({s_ready, busy}), 1);
        seen   = 1'b0;
        doneat = 0;
        for (int j = 0; j < 500 && !seen; j++) begin
            @(posedge clk); #1;
            m_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = (inj != 0) && (j == 0);
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                doneat = cyc;
                chk({tag, "_busy_at_done"}, int'(busy), 0);
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        chk({tag, "_done_seen"}, int'(seen), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_out_count"}, obs_q.size() - base, NO);
        for (int i = 0; i < NO; i++) begin
            if (base + i < obs_q.size()) begin
                o = obs_q[base + i];
                chk($sformatf("%s_pix%0d", tag, i), int'(o.pix), exp_o[i]);
                chk($sformatf("%s_last%0d", tag, i), int'(o.last), (i == NO - 1) ? 1 : 0);
            end
        end
        if (seen && obs_q.size() >= base + NO)
            chk({tag, "_done_latency"}, doneat - obs_q[base + NO - 1].cyc, 1);
    endtask

    typedef struct packed {
        int              kind;
        int              vmode;
        int              rmode;
        int              inj;
        logic [8*NO-1:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int im[NP];
        int exp_o[NO];

        // kind, s_valid mode, m_ready mode, start injection, expected outputs in order
        tbl[0] = '{0, 0, 0, 0, 32'h28282828};  // ramp 4r+c: |8|+|32|
        tbl[1] = '{1, 1, 0, 0, 32'hFFFFFFFF};  // 255 left / 0 right
        tbl[2] = '{2, 0, 1, 0, 32'h00000000};  // flat 255, output stalled 40 cycles
        tbl[3] = '{3, 1, 2, 1, 32'h50505050};  // column ramp 10c
        tbl[4] = '{4, 2, 2, 1, 32'hFFFFFFFF};  // 255 top / 0 bottom

        s_valid = 1'b1;
        s_pixel = 8'hC3;
        #2;
        chk("reset_ctrl", int'({s_ready, m_valid, m_last, busy, done, core_valid_in, core_rst}), 1);
        chk("reset_m_pixel", int'(m_pixel), 0);
        chk("reset_core_pixel_in", int'(core_pixel_in), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", int'({core_rst, busy, s_ready}), 0);

        for (int t = 0; t < 5; t++) begin
            make_img(tbl[t].kind, im);
            for (int i = 0; i < NO; i++) exp_o[i] = int'(tbl[t].exp[8*(NO-1-i) +: 8]);
            run_frame(im, exp_o, tbl[t].vmode, tbl[t].rmode, tbl[t].inj, $sformatf("vec%0d", t));
        end

        for (int f = 0; f < 4; f++) begin
            make_img(99, im);
            golden(im, exp_o);
            run_frame(im, exp_o, f % 3, (f + 1) % 3, f % 2, $sformatf("rnd%0d", f));
        end

        // Abort a frame after 7 accepted beats, then run a fresh one.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int beats;
            int guard;
            logic acc;
            beats = 0;
            guard = 0;
            while (beats < 7 && guard < 100) begin
                s_valid = 1'b1;
                s_pixel = 8'($urandom_range(0, 255));
                @(negedge clk);
                acc = s_valid && s_ready;
                @(posedge clk); #1;
                if (acc) beats = beats + 1;
                guard = guard + 1;
            end
            chk("abort_beats", beats, 7);
        end
        rst_n   = 1'b0;
        s_pixel = 8'hA5;
        #1;
        chk("midreset_ctrl", int'({s_ready, m_valid, m_last, busy, done, core_valid_in, core_rst}), 1);
        chk("midreset_core_pixel_in", int'(core_pixel_in), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("midreset_release", int'({core_rst, busy}), 0);
        make_img(99, im);
        golden(im, exp_o);
        run_frame(im, exp_o, 1, 2, 0, "fresh");

        chk("fifo_max_count", max_cnt, D);
        chk("sready_while_full", full_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
